// File: rtl/laa_mul_sequencer.sv
// LAA multiply-path command controller: owns the A/B/RES banks and the status word, and
// sequences a word-serial product-scanning multiply through an external pipelined multiplier.
`timescale 1ns/1ps
module laa_mul_sequencer #(
    parameter int unsigned NWORDS  = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned IDXW    = $clog2(2 * NWORDS)
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [IDXW-1:0] cmd_idx,
    input  logic [31:0]     cmd_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic [31:0]     mul_a,
    output logic [31:0]     mul_b,
    output logic            mul_in_valid,
    input  logic [63:0]     mul_p,
    input  logic            mul_out_valid,
    output logic            busy,
    output logic            done_irq
);
    localparam int unsigned     AW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned     CW    = $clog2(NWORDS + MUL_LAT + 1);
    localparam logic [IDXW-1:0] NM1   = IDXW'(NWORDS - 1);
    localparam logic [IDXW-1:0] LASTK = IDXW'(2 * NWORDS - 2);
    localparam logic [7:0]      NW8   = 8'(NWORDS);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_FINAL} state_t;
    typedef enum logic [2:0] {
        OP_WR_A, OP_WR_B, OP_RD_A, OP_RD_B, OP_RD_RES, OP_START, OP_RD_CTRL, OP_CLEAR
    } op_t;

    state_t          state, state_nx;
    op_t             op;
    logic [31:0]     a_bank   [NWORDS];
    logic [31:0]     b_bank   [NWORDS];
    logic [31:0]     res_bank [2*NWORDS];
    logic [95:0]     acc, acc_nx;
    logic [CW-1:0]   outstanding, out_nx;
    logic [IDXW-1:0] col_k, i_hi, k_nx, i_lo_nx;
    logic [AW-1:0]   row_i, col_j, ab_idx;
    logic            done_flag, err_flag;
    logic            accept, ab_ok, res_ok, last_pair, ret;

    assign op     = op_t'(cmd_op);
    assign accept = cmd_valid && cmd_ready;
    assign ab_ok  = 32'(cmd_idx) < NWORDS;
    assign ab_idx = cmd_idx[AW-1:0];

    if ((2 * NWORDS) == (1 << IDXW)) begin : g_res_full
        assign res_ok = 1'b1;
    end else begin : g_res_part
        assign res_ok = 32'(cmd_idx) < 2 * NWORDS;
    end

    // Column k pairs A[i] with B[k-i] for max(0,k-N+1) <= i <= min(k,N-1).
    assign col_j     = AW'(col_k - IDXW'(row_i));
    assign i_hi      = (col_k > NM1) ? NM1 : col_k;
    assign last_pair = (IDXW'(row_i) == i_hi);
    assign k_nx      = col_k + IDXW'(1);
    assign i_lo_nx   = (k_nx > NM1) ? (k_nx - NM1) : '0;

    assign ret    = mul_out_valid && (state != S_IDLE);
    assign out_nx = outstanding + CW'(mul_in_valid) - CW'(ret && (outstanding != '0));
    assign busy   = (state != S_IDLE);
    assign mul_a  = mul_in_valid ? a_bank[row_i] : '0;
    assign mul_b  = mul_in_valid ? b_bank[col_j] : '0;

    always_comb begin
        acc_nx = (state == S_WRITE) ? (acc >> 32) : acc;
        if (ret) begin
            acc_nx = acc_nx + {32'b0, mul_p};
        end
    end

    always_comb begin
        state_nx     = state;
        cmd_ready    = (state == S_IDLE) || (op == OP_RD_CTRL);
        mul_in_valid = 1'b0;
        case (state)
            S_IDLE:  if (cmd_valid && op == OP_START) state_nx = S_ISSUE;
            S_ISSUE: begin
                mul_in_valid = 1'b1;
                if (last_pair) state_nx = S_DRAIN;
            end
            S_DRAIN: if (outstanding == '0) state_nx = S_WRITE;
            S_WRITE: state_nx = (col_k == LASTK) ? S_FINAL : S_ISSUE;
            S_FINAL: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned w = 0; w < NWORDS; w++) begin
                a_bank[w] <= '0;
                b_bank[w] <= '0;
            end
            for (int unsigned w = 0; w < 2 * NWORDS; w++) res_bank[w] <= '0;
            acc         <= '0;
            outstanding <= '0;
            col_k       <= '0;
            row_i       <= '0;
            done_flag   <= 1'b0;
            err_flag    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            done_irq    <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            done_irq    <= (state == S_FINAL);
            acc         <= acc_nx;
            outstanding <= out_nx;
            case (state)
                S_ISSUE: if (!last_pair) row_i <= row_i + AW'(1);
                S_WRITE: begin
                    res_bank[col_k] <= acc[31:0];
                    col_k           <= k_nx;
                    row_i           <= AW'(i_lo_nx);
                end
                S_FINAL: begin
                    res_bank[col_k] <= acc[31:0];
                    done_flag       <= 1'b1;
                end
                default: ;
            endcase
            if (accept) begin
                case (op)
                    OP_WR_A: if (ab_ok) a_bank[ab_idx] <= cmd_wdata; else err_flag <= 1'b1;
                    OP_WR_B: if (ab_ok) b_bank[ab_idx] <= cmd_wdata; else err_flag <= 1'b1;
                    OP_RD_A: begin
                        rsp_valid <= 1'b1;
                        if (ab_ok) rsp_rdata <= a_bank[ab_idx]; else err_flag <= 1'b1;
                    end
                    OP_RD_B: begin
                        rsp_valid <= 1'b1;
                        if (ab_ok) rsp_rdata <= b_bank[ab_idx]; else err_flag <= 1'b1;
                    end
                    OP_RD_RES: begin
                        rsp_valid <= 1'b1;
                        if (res_ok) rsp_rdata <= res_bank[cmd_idx]; else err_flag <= 1'b1;
                    end
                    OP_START: begin
                        done_flag <= 1'b0;
                        for (int unsigned w = 0; w < 2 * NWORDS; w++) res_bank[w] <= '0;
                        acc   <= '0;
                        col_k <= '0;
                        row_i <= '0;
                    end
                    OP_RD_CTRL: begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= {16'b0, NW8, 5'b0, err_flag, done_flag, busy};
                    end
                    OP_CLEAR: begin
                        done_flag <= 1'b0;
                        err_flag  <= 1'b0;
                        for (int unsigned w = 0; w < 2 * NWORDS; w++) res_bank[w] <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_laa_mul_sequencer.sv
// Scoreboard bench for laa_mul_sequencer: random operands checked against a
// big-integer product model, with a behavioural pipelined multiplier.
`timescale 1ns/1ps
module tb_laa_mul_sequencer;
    localparam int unsigned N     = 4;
    localparam int unsigned L     = 2;
    localparam int unsigned IW    = $clog2(2 * N);
    localparam int unsigned BOUND = N * N + (2 * N - 1) * (L + 2) + 2;
    localparam int unsigned PW    = 64 * N;
    localparam logic [2:0] WR_A = 3'd0, WR_B = 3'd1, RD_A = 3'd2, RD_B = 3'd3,
                           RD_RES = 3'd4, START = 3'd5, RD_CTRL = 3'd6, CLEAR = 3'd7;

    logic          clk = 1'b0, Rst = 1'b0, cmd_valid = 1'b0;
    logic [2:0]    cmd_op = '0;
    logic [IW-1:0] cmd_idx = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          cmd_ready, rsp_valid, mul_in_valid, mul_out_valid, busy, done_irq;
    logic [31:0]   rsp_rdata, mul_a, mul_b;
    logic [63:0]   mul_p;

    laa_mul_sequencer #(.NWORDS(N), .MUL_LAT(L)) dut (
        .clk(clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid), .mul_p(mul_p),
        .mul_out_valid(mul_out_valid), .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Pipelined multiplier; deliberately not reset so in-flight products outlive a DUT reset.
    logic [L-1:0] pv = '0;
    logic [63:0]  pp [L];
    always @(posedge clk) begin
        pv[0] <= mul_in_valid;
        pp[0] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int s = 1; s < L; s++) begin
            pv[s] <= pv[s-1];
            pp[s] <= pp[s-1];
        end
    end
    assign mul_out_valid = pv[L-1];
    assign mul_p         = pp[L-1];

    typedef struct {
        logic [31:0] exp;
        logic [31:0] alt;
        bit          has_alt;
        string       name;
    } exp_t;
    exp_t sbq[$];

    int          n_cmp = 0, n_mis = 0;
    int          irq_cnt = 0, irq_base = 0;
    time         irq_t = 0, start_t = 0;
    logic [31:0] mA [N];
    logic [31:0] mB [N];
    logic [31:0] mRes [2*N];
    bit          mdone = 0, merr = 0, mrun = 0, strict_next = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ctrl_word(bit b, bit d);
        logic [7:0] nw = 8'(N);
        return {16'h0, nw, 5'h0, merr, d, b};
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < N; w++) begin mA[w] = '0; mB[w] = '0; end
        for (int w = 0; w < 2 * N; w++) mRes[w] = '0;
        mdone = 0; merr = 0; mrun = 0;
    endfunction

    function automatic void model_product();
        logic [PW-1:0] af, bf, p;
        af = '0; bf = '0;
        for (int w = 0; w < N; w++) begin
            af[32*w +: 32] = mA[w];
            bf[32*w +: 32] = mB[w];
        end
        p = af * bf;
        for (int w = 0; w < 2 * N; w++) mRes[w] = p[32*w +: 32];
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (Rst && rsp_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL unexpected_rsp: got 0x%08h expected no response", rsp_rdata);
                end else begin
                    e = sbq.pop_front();
                    if (e.has_alt && rsp_rdata === e.alt) chk(e.name, rsp_rdata, e.alt);
                    else chk(e.name, rsp_rdata, e.exp);
                end
            end
        end
    endtask

    task automatic irq_watch();
        bit prev = 0;
        forever begin
            @(negedge clk);
            if (done_irq) begin
                irq_cnt++;
                irq_t = $time;
                chk("irq_width", {31'b0, prev}, 32'd0);
            end
            prev = done_irq;
        end
    endtask

    task automatic send(input logic [2:0] op, input int unsigned idx, input logic [31:0] wd);
        int unsigned waited = 0;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = IW'(idx); cmd_wdata = wd;
        #1;
        while (!cmd_ready && waited < 400) begin
            chk("stall_only_busy", {31'b0, busy}, 32'd1);
            @(negedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_mis++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 400 cycles");
            cmd_valid = 1'b0;
            return;
        end
        if (op != RD_CTRL) chk("accept_idle", {31'b0, busy}, 32'd0);
        @(posedge clk);
        e.has_alt = 0; e.alt = '0; e.exp = '0; e.name = "";
        case (op)
            WR_A:  if (idx < N) mA[idx] = wd; else merr = 1;
            WR_B:  if (idx < N) mB[idx] = wd; else merr = 1;
            RD_A:  begin e.name = "rd_a"; if (idx < N) e.exp = mA[idx]; else merr = 1; end
            RD_B:  begin e.name = "rd_b"; if (idx < N) e.exp = mB[idx]; else merr = 1; end
            RD_RES: begin e.name = "rd_res"; if (idx < 2 * N) e.exp = mRes[idx]; else merr = 1; end
            START: begin
                mdone = 0; mrun = 1; model_product();
                start_t = $time; irq_base = irq_cnt;
            end
            RD_CTRL: begin
                e.name = "rd_ctrl";
                e.exp  = ctrl_word(mrun, mdone);
                // A run may finish any cycle; only the first poll after START is known to be mid-run.
                if (mrun && !strict_next) begin e.has_alt = 1; e.alt = ctrl_word(0, 1); end
                strict_next = 0;
            end
            CLEAR: begin
                mdone = 0; merr = 0;
                for (int w = 0; w < 2 * N; w++) mRes[w] = '0;
            end
            default: ;
        endcase
        if (op == RD_A || op == RD_B || op == RD_RES || op == RD_CTRL) sbq.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == RD_A || op == RD_B || op == RD_RES || op == RD_CTRL)
            chk("rsp_latency", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_done();
        int unsigned t = 0;
        int unsigned cyc;
        while (irq_cnt == irq_base && t < 300) begin @(negedge clk); t++; end
        if (irq_cnt == irq_base) begin
            n_cmp++; n_mis++;
            $display("FAIL done_timeout: got no done_irq expected one within 300 cycles");
            mrun = 0;
            return;
        end
        cyc = int'((irq_t - start_t + 5) / 10);
        n_cmp++;
        if (cyc > BOUND) begin
            n_mis++;
            $display("FAIL latency: got %0d cycles expected <= %0d", cyc, BOUND);
        end
        repeat (3) @(negedge clk);
        chk("irq_once", 32'(irq_cnt - irq_base), 32'd1);
        mrun = 0; mdone = 1;
    endtask

    task automatic run_poll();
        int unsigned k = 0;
        send(START, 0, 0);
        strict_next = 1;
        while (irq_cnt == irq_base && k < 100) begin send(RD_CTRL, 0, 0); k++; end
        wait_done();
    endtask

    task automatic read_all_res();
        for (int w = 0; w < 2 * N; w++) send(RD_RES, w, 0);
    endtask

    initial begin
        model_reset();
        fork
            monitor();
            irq_watch();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_miv", {31'b0, mul_in_valid}, 32'd0);
        chk("rst_irq", {31'b0, done_irq}, 32'd0);
        chk("rst_rsp", {31'b0, rsp_valid}, 32'd0);
        Rst = 1'b1;
        send(RD_CTRL, 0, 0);
        read_all_res();

        // 1 x 1
        send(WR_A, 0, 32'd1);
        send(WR_B, 0, 32'd1);
        run_poll();
        read_all_res();
        send(RD_CTRL, 0, 0);

        // all-ones operands
        for (int w = 0; w < N; w++) begin send(WR_A, w, '1); send(WR_B, w, '1); end
        send(START, 0, 0);
        wait_done();
        read_all_res();

        // write during busy stalls until idle; product uses operands captured before
        for (int w = 0; w < N; w++) begin send(WR_A, w, $urandom); send(WR_B, w, $urandom); end
        send(START, 0, 0);
        strict_next = 1;
        send(RD_CTRL, 0, 0);
        send(WR_A, 2, 32'hA5A5_0001);
        wait_done();
        read_all_res();
        send(RD_A, 2, 0);

        // out-of-range index handling
        send(CLEAR, 0, 0);
        send(RD_CTRL, 0, 0);
        send(WR_A, N, 32'hDEAD_BEEF);
        for (int w = 0; w < N; w++) send(RD_A, w, 0);
        send(RD_CTRL, 0, 0);
        send(RD_A, N, 0);
        send(RD_B, N + 1, 0);
        send(CLEAR, 0, 0);
        send(RD_CTRL, 0, 0);

        // randomized runs
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < N; w++) begin
                send(WR_A, ($urandom_range(0, 7) == 0) ? $urandom_range(N, 2 * N - 1) : w, $urandom);
                send(WR_B, w, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
            end
            send(RD_A, $urandom_range(0, N - 1), 0);
            send(RD_B, $urandom_range(0, N - 1), 0);
            run_poll();
            read_all_res();
            send(RD_CTRL, 0, 0);
            if ($urandom_range(0, 1) == 1) send(CLEAR, 0, 0);
        end

        // reset in the middle of column 1's issue, with products still in the multiplier
        for (int w = 0; w < N; w++) begin send(WR_A, w, $urandom | 1); send(WR_B, w, $urandom | 1); end
        send(START, 0, 0);
        repeat (6) @(negedge clk);
        chk("mid_issue", {31'b0, mul_in_valid}, 32'd1);
        Rst = 1'b0;
        #1;
        chk("rst_async_busy", {31'b0, busy}, 32'd0);
        chk("rst_async_miv", {31'b0, mul_in_valid}, 32'd0);
        @(negedge clk);
        Rst = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        read_all_res();
        send(RD_CTRL, 0, 0);
        for (int w = 0; w < N; w++) send(RD_A, w, 0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected $finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
